// File: rtl/cond_logic.sv
// Condition-code evaluation and NZCV flag register.
// Qualifies decoder write/branch requests with the instruction condition.
module cond_logic #(
    parameter int FLAG_W = 4,
    parameter int COND_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              En,
    input  logic [COND_W-1:0] Cond,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NoWrite,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic [FLAG_W-1:0] Flags
);

    logic [FLAG_W-1:0] r_flags;
    logic              w_n;
    logic              w_z;
    logic              w_c;
    logic              w_v;
    logic              w_cond_ex;
    logic              w_upd_nz;
    logic              w_upd_cv;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Evaluate condition code against the registered flags only.
    always_comb begin
        w_cond_ex = 1'b0;
        unique case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Qualified write enables; reset squashes everything.
    always_comb begin
        PCSrc    = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        if (!reset) begin
            PCSrc    = PCS & w_cond_ex;
            RegWrite = RegW & w_cond_ex & ~NoWrite;
            MemWrite = MemW & w_cond_ex;
        end
    end

    assign w_upd_nz = En & FlagW[1] & w_cond_ex;
    assign w_upd_cv = En & FlagW[0] & w_cond_ex;

    // Flag register: two groups update independently; reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else begin
            if (w_upd_nz) r_flags[3:2] <= ALUFlags[3:2];
            if (w_upd_cv) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign Flags = r_flags;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic.
// Directed test-plan steps followed by randomized traffic.
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic       En;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;

    int         n_cmp;
    int         n_err;
    logic [3:0] m;

    cond_logic dut (
        .clk      (clk),
        .reset    (reset),
        .En       (En),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: conditions come in true/inverse pairs selected by Cond[0].
    function automatic logic cond_ok(input logic [3:0] c,
                                     input logic [3:0] f);
        logic n, z, cy, v, base;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return !c[0];
        return base ^ c[0];
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set(input logic rst, input logic en,
                       input logic [3:0] c, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pcs,
                       input logic rw, input logic mw, input logic nw);
        reset    = rst;
        En       = en;
        Cond     = c;
        ALUFlags = alu;
        FlagW    = fw;
        PCS      = pcs;
        RegW     = rw;
        MemW     = mw;
        NoWrite  = nw;
    endtask

    // Check combinational outputs, clock once, check the flag register.
    task automatic step(input string tag);
        logic       ok;
        logic [3:0] nx;
        #2;
        ok = cond_ok(Cond, m);
        chk({tag, "_pcsrc"}, {3'b0, PCSrc}, {3'b0, !reset && PCS && ok});
        chk({tag, "_regwr"}, {3'b0, RegWrite},
            {3'b0, !reset && RegW && ok && !NoWrite});
        chk({tag, "_memwr"}, {3'b0, MemWrite}, {3'b0, !reset && MemW && ok});
        nx = m;
        if (reset) begin
            nx = 4'b0000;
        end else if (En && ok) begin
            if (FlagW[1]) nx[3:2] = ALUFlags[3:2];
            if (FlagW[0]) nx[1:0] = ALUFlags[1:0];
        end
        @(posedge clk);
        #1;
        m = nx;
        chk({tag, "_flags"}, Flags, m);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m     = 4'b0000;

        set(1, 1, 4'he, 4'h0, 2'b00, 1, 1, 1, 0);
        step("reset0");
        step("reset1");
        set(0, 1, 4'he, 4'h0, 2'b00, 1, 1, 1, 0);
        step("al");
        chk("al_flags0", Flags, 4'b0000);

        set(0, 1, 4'he, 4'h6, 2'b11, 0, 1, 0, 1);
        step("cmp");
        chk("cmp_flags", Flags, 4'b0110);
        set(0, 1, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
        #2;
        chk("beq_taken", {3'b0, PCSrc}, 4'h1);
        step("beq");
        set(0, 1, 4'h1, 4'h0, 2'b00, 1, 0, 0, 0);
        #2;
        chk("bne_not", {3'b0, PCSrc}, 4'h0);
        step("bne");

        set(0, 1, 4'he, 4'hf, 2'b11, 0, 0, 0, 0);
        step("load_f");
        set(0, 1, 4'he, 4'h0, 2'b10, 0, 0, 0, 0);
        step("partial");
        chk("partial_val", Flags, 4'b0011);

        set(0, 1, 4'he, 4'h0, 2'b11, 0, 0, 0, 0);
        step("load_0");
        set(0, 1, 4'h0, 4'hf, 2'b11, 0, 1, 1, 0);
        step("condfail");
        chk("condfail_val", Flags, 4'b0000);

        set(0, 1, 4'he, 4'h5, 2'b11, 0, 0, 0, 0);
        step("load_5");
        set(0, 0, 4'he, 4'ha, 2'b11, 1, 1, 1, 0);
        step("stall");
        chk("stall_val", Flags, 4'b0101);
        set(1, 1, 4'he, 4'ha, 2'b11, 1, 1, 1, 0);
        step("rst_pri");
        chk("rst_pri_val", Flags, 4'b0000);

        for (int f = 0; f < 16; f++) begin
            set(0, 1, 4'he, 4'(f), 2'b11, 0, 0, 0, 0);
            step("sweep_load");
            for (int c = 0; c < 16; c++) begin
                set(0, 0, 4'(c), 4'h0, 2'b00, 1, 1, 1, 0);
                #1;
                chk("sweep", {3'b0, PCSrc}, {3'b0, cond_ok(4'(c), 4'(f))});
                if (f == 9 && c == 10) chk("spot_ge", {3'b0, PCSrc}, 4'h1);
                if (f == 9 && c == 11) chk("spot_lt", {3'b0, PCSrc}, 4'h0);
                if (f == 2 && c == 8)  chk("spot_hi", {3'b0, PCSrc}, 4'h1);
                if (f == 2 && c == 9)  chk("spot_ls", {3'b0, PCSrc}, 4'h0);
            end
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 400; i++) begin
            set(($urandom % 16) == 0, 1'($urandom), 4'($urandom),
                4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
